// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounces mode/up keys and sequences RUN / SET_HOUR / SET_MIN,
// producing seconds enable/clear, hour/minute increment strobes and digit blanking.

// Key debouncer: 2-flop synchronizer, then a stability counter that accepts a new level
// after DB_CYCLES consecutive mismatching samples. press pulses one cycle on a 1->0 flip.
module time_set_db #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          lock;

  // Synchronizer keeps tracking the pin during reset, so a key held through reset
  // is seen low at exit and the lock suppresses its press event until a release.
  always_ff @(posedge clk) begin
    sync1 <= raw;
    sync2 <= sync1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
      lock  <= 1'b1;
    end else begin
      press <= 1'b0;
      if (sync2) lock <= 1'b0;
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= ~sync2 & ~lock;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// States:
//   RUN      | clock running, sec_en follows EN
//   SET_HOUR | up key strobes hour_inc, hour digits blink
//   SET_MIN  | up key strobes min_inc, minute digits blink
module time_set_ctrl #(
  parameter int DB_CYCLES    = 16,
  parameter int REPEAT_DELAY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       tick_1hz,
  input  logic       tick_fast,
  output logic [1:0] mode,
  output logic       sec_en,
  output logic       sec_clr,
  output logic       hour_inc,
  output logic       min_inc,
  output logic       blank_hour,
  output logic       blank_min
);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RD_MAX  = RW'(REPEAT_DELAY);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  state_t        state, nxt_state;
  logic          phase, nxt_phase;
  logic          rep_active, nxt_active;
  logic [RW-1:0] rep_cnt, nxt_cnt;
  logic          inc, clr;
  logic          mode_lvl, mode_ev, up_lvl, up_ev;
  logic          in_set;

  time_set_db #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk(clk), .rst(rst), .raw(key_mode), .level(mode_lvl), .press(mode_ev)
  );

  time_set_db #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .raw(key_up), .level(up_lvl), .press(up_ev)
  );

  assign in_set = (state != RUN);
  assign mode   = state;

  always_comb begin
    nxt_state  = state;
    nxt_phase  = phase;
    nxt_active = rep_active;
    nxt_cnt    = rep_cnt;
    inc        = 1'b0;
    clr        = 1'b0;

    if (EN && mode_ev) begin
      case (state)
        RUN:      nxt_state = SET_HOUR;
        SET_HOUR: nxt_state = SET_MIN;
        default: begin
          nxt_state = RUN;
          clr       = 1'b1;
        end
      endcase
    end

    // Mode press outranks a coincident up press and cancels any repeat in progress.
    if (!EN || mode_ev || up_lvl) begin
      nxt_active = 1'b0;
      nxt_cnt    = '0;
    end else if (up_ev && in_set) begin
      inc        = 1'b1;
      nxt_active = 1'b1;
      nxt_cnt    = '0;
    end else if (rep_active && tick_fast) begin
      if (rep_cnt >= RD_LAST) begin
        inc     = 1'b1;
        nxt_cnt = RD_MAX;
      end else begin
        nxt_cnt = rep_cnt + 1'b1;
      end
    end

    if (EN) begin
      if (nxt_state != state || !up_lvl) nxt_phase = 1'b0;
      else if (in_set && tick_1hz)       nxt_phase = ~phase;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      phase      <= 1'b0;
      rep_active <= 1'b0;
      rep_cnt    <= '0;
      sec_en     <= 1'b0;
      sec_clr    <= 1'b0;
      hour_inc   <= 1'b0;
      min_inc    <= 1'b0;
      blank_hour <= 1'b0;
      blank_min  <= 1'b0;
    end else begin
      state      <= nxt_state;
      phase      <= nxt_phase;
      rep_active <= nxt_active;
      rep_cnt    <= nxt_cnt;
      sec_en     <= EN && (nxt_state == RUN);
      sec_clr    <= clr;
      hour_inc   <= inc && (state == SET_HOUR);
      min_inc    <= inc && (state == SET_MIN);
      blank_hour <= (nxt_state == SET_HOUR) && nxt_phase;
      blank_min  <= (nxt_state == SET_MIN) && nxt_phase;
    end
  end
endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with DB_CYCLES=16, REPEAT_DELAY=4.
module tb_time_set_ctrl;
  logic       clk = 1'b0;
  logic       rst, EN, key_mode, key_up, tick_1hz, tick_fast;
  logic [1:0] mode;
  logic       sec_en, sec_clr, hour_inc, min_inc, blank_hour, blank_min;

  int errors = 0;
  int checks = 0;
  int n_h = 0, n_m = 0, n_clr = 0;
  int base_h, base_m;

  time_set_ctrl #(.DB_CYCLES(16), .REPEAT_DELAY(4)) dut (
    .clk(clk), .rst(rst), .EN(EN), .key_mode(key_mode), .key_up(key_up),
    .tick_1hz(tick_1hz), .tick_fast(tick_fast), .mode(mode), .sec_en(sec_en),
    .sec_clr(sec_clr), .hour_inc(hour_inc), .min_inc(min_inc),
    .blank_hour(blank_hour), .blank_min(blank_min)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (hour_inc) n_h++;
    if (min_inc)  n_m++;
    if (sec_clr)  n_clr++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_mode();
    key_mode = 1'b0;
    steps(19);
    key_mode = 1'b1;
    steps(20);
  endtask

  task automatic fast_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick_fast = 1'b1;
      step();
      tick_fast = 1'b0;
      steps(3);
    end
  endtask

  initial begin
    int exp_blink[4];
    exp_blink[0] = 1; exp_blink[1] = 0; exp_blink[2] = 1; exp_blink[3] = 0;

    rst = 1'b1; EN = 1'b1; key_mode = 1'b1; key_up = 1'b1;
    tick_1hz = 1'b0; tick_fast = 1'b0;
    steps(4);
    chk("reset_mode", mode, 0);
    chk("reset_sec_en", sec_en, 0);
    chk("reset_strobes", {sec_clr, hour_inc, min_inc, blank_hour, blank_min}, 0);
    rst = 1'b0;
    step();
    chk("sec_en_after_reset", sec_en, 1);
    n_h = 0; n_m = 0; n_clr = 0;
    steps(1000);
    chk("idle_strobes", n_h + n_m + n_clr, 0);
    chk("idle_mode", mode, 0);

    // short glitch on mode key
    key_mode = 1'b0;
    steps(10);
    key_mode = 1'b1;
    steps(30);
    chk("glitch_mode", mode, 0);

    // exact latency of a mode press
    key_mode = 1'b0;
    steps(18);
    chk("mode_at_18", mode, 0);
    step();
    chk("mode_at_19", mode, 1);
    chk("sec_en_set_hour", sec_en, 0);
    key_mode = 1'b1;
    steps(20);

    press_mode();
    chk("mode_set_min", mode, 2);
    key_mode = 1'b0;
    steps(19);
    chk("mode_back_run", mode, 0);
    chk("sec_clr_pulse", sec_clr, 1);
    step();
    chk("sec_clr_one_cycle", sec_clr, 0);
    chk("sec_en_back", sec_en, 1);
    key_mode = 1'b1;
    steps(20);
    chk("sec_clr_total", n_clr, 1);

    // auto-repeat in SET_HOUR
    press_mode();
    base_h = n_h; base_m = n_m;
    key_up = 1'b0;
    steps(19);
    chk("first_hour_inc", hour_inc, 1);
    fast_pulses(7);
    chk("repeat_hour_count", n_h - base_h, 5);
    chk("repeat_no_min", n_m - base_m, 0);
    key_up = 1'b1;
    steps(20);

    // same stimulus in RUN gives nothing
    press_mode();
    press_mode();
    chk("mode_run_again", mode, 0);
    base_h = n_h; base_m = n_m;
    key_up = 1'b0;
    steps(19);
    fast_pulses(7);
    chk("run_no_strobes", (n_h - base_h) + (n_m - base_m), 0);
    key_up = 1'b1;
    steps(20);

    // blink in SET_MIN
    press_mode();
    press_mode();
    chk("mode_set_min2", mode, 2);
    chk("blank_min_entry", blank_min, 0);
    for (int k = 0; k < 4; k++) begin
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      chk("blink_min", blank_min, exp_blink[k]);
      chk("blink_hour_off", blank_hour, 0);
      steps(3);
    end
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    chk("blink_min_fifth", blank_min, 1);
    base_m = n_m;
    key_up = 1'b0;
    steps(19);
    chk("up_forces_blank_off", blank_min, 0);
    chk("min_inc_press", n_m - base_m, 1);
    key_up = 1'b1;
    steps(20);

    // simultaneous mode and up press in SET_HOUR
    press_mode();
    press_mode();
    chk("mode_set_hour2", mode, 1);
    base_h = n_h; base_m = n_m;
    key_mode = 1'b0;
    key_up = 1'b0;
    steps(19);
    chk("simul_mode", mode, 2);
    chk("simul_no_inc", (n_h - base_h) + (n_m - base_m), 0);
    key_mode = 1'b1;
    key_up = 1'b1;
    steps(20);

    // reset in the middle of an auto-repeat in SET_MIN
    base_m = n_m;
    key_up = 1'b0;
    steps(19);
    fast_pulses(4);
    chk("pre_reset_min_count", n_m - base_m, 2);
    tick_fast = 1'b1;
    rst = 1'b1;
    step();
    chk("rst_mode", mode, 0);
    chk("rst_outputs", {sec_en, sec_clr, hour_inc, min_inc, blank_hour, blank_min}, 0);
    rst = 1'b0;
    tick_fast = 1'b0;
    step();
    chk("rst_exit_sec_en", sec_en, 1);
    base_h = n_h;
    press_mode();
    chk("held_up_mode", mode, 1);
    chk("held_up_no_event", n_h - base_h, 0);
    key_up = 1'b1;
    steps(20);
    key_up = 1'b0;
    steps(19);
    chk("repress_hour_inc", n_h - base_h, 1);
    key_up = 1'b1;
    steps(20);

    // EN low discards presses and drops sec_en
    EN = 1'b0;
    press_mode();
    chk("en_low_mode_hold", mode, 1);
    EN = 1'b1;
    steps(2);
    chk("en_press_not_queued", mode, 1);
    press_mode();
    press_mode();
    chk("run_before_en_drop", sec_en, 1);
    EN = 1'b0;
    step();
    chk("en_drop_sec_en", sec_en, 0);
    chk("en_drop_mode", mode, 0);
    EN = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
